// File: rtl/mult_div_unit.sv
// Iterative 32-bit MIPS multiply/divide unit with architectural HI/LO registers.
// Signed MULT/DIV handling is compiled in only when MULDIV_SIGNED_EN is defined.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_rs_data,
  input  logic [WIDTH-1:0] i_rt_data,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e               r_state, w_state_next;
  logic [CntW-1:0]      r_cnt;
  logic                 r_is_div, r_dz, r_neg_res, r_neg_rem;
  logic [WIDTH-1:0]     r_opnd, r_rs, r_hi, r_lo;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_done, r_dz_pulse;

  // Operand magnitudes and result signs captured at start.
  logic [WIDTH-1:0]     w_mag_a, w_mag_b;
  logic                 w_neg_res, w_neg_rem;

`ifdef MULDIV_SIGNED_EN
  logic w_a_neg, w_b_neg;
  assign w_a_neg   = i_op[0] & i_rs_data[WIDTH-1];
  assign w_b_neg   = i_op[0] & i_rt_data[WIDTH-1];
  assign w_mag_a   = w_a_neg ? -i_rs_data : i_rs_data;
  assign w_mag_b   = w_b_neg ? -i_rt_data : i_rt_data;
  assign w_neg_res = w_a_neg ^ w_b_neg;
  assign w_neg_rem = w_a_neg;
`else
  logic w_unused_op0;
  assign w_unused_op0 = i_op[0];
  assign w_mag_a   = i_rs_data;
  assign w_mag_b   = i_rt_data;
  assign w_neg_res = 1'b0;
  assign w_neg_rem = 1'b0;
`endif

  // Multiply: acc = {partial product, remaining multiplier bits}, shift right each step.
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}, restoring shift-subtract.
  // When the trial subtraction succeeds the difference always fits in WIDTH bits.
  logic [WIDTH:0]       w_div_shift;
  logic                 w_div_ge;
  logic [WIDTH-1:0]     w_div_rem;
  logic [2*WIDTH-1:0]   w_div_next;
  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_ge    = w_div_shift >= {1'b0, r_opnd};
  assign w_div_rem   = w_div_ge ? (w_div_shift[WIDTH-1:0] - r_opnd) : w_div_shift[WIDTH-1:0];
  assign w_div_next  = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};

  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quot, w_rem, w_fix_hi, w_fix_lo;
  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quot = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_dz) begin
        w_fix_hi = r_rs;
        w_fix_lo = '1;
      end else begin
        w_fix_hi = w_rem;
        w_fix_lo = w_quot;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StCalc;
      StCalc:  if (r_cnt == '0) w_state_next = StFix;
      StFix:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= StIdle;
    else            r_state <= w_state_next;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_dz       <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_opnd     <= '0;
      r_rs       <= '0;
      r_acc      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_dz_pulse <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_dz_pulse <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_cnt     <= CntW'(WIDTH - 1);
            r_is_div  <= i_op[1];
            r_dz      <= (i_rt_data == '0);
            r_neg_res <= w_neg_res;
            r_neg_rem <= w_neg_rem;
            r_rs      <= i_rs_data;
            r_opnd    <= i_op[1] ? w_mag_b : w_mag_a;
            r_acc     <= {{WIDTH{1'b0}}, (i_op[1] ? w_mag_a : w_mag_b)};
          end else begin
            if (i_mthi) r_hi <= i_wdata;
            if (i_mtlo) r_lo <= i_wdata;
          end
        end
        StCalc: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        StFix: begin
          r_hi       <= w_fix_hi;
          r_lo       <= w_fix_lo;
          r_done     <= 1'b1;
          r_dz_pulse <= r_is_div & r_dz;
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state != StIdle);
  assign o_done        = r_done;
  assign o_div_by_zero = r_dz_pulse;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit; expectations follow MULDIV_SIGNED_EN when defined.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = '0, rt_data = '0, wdata = '0;
  logic        mthi = 1'b0, mtlo = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_start       (start),
    .i_op          (op),
    .i_rs_data     (rs_data),
    .i_rt_data     (rt_data),
    .i_mthi        (mthi),
    .i_mtlo        (mtlo),
    .i_wdata       (wdata),
    .o_busy        (busy),
    .o_done        (done),
    .o_div_by_zero (div_by_zero),
    .o_hi          (hi),
    .o_lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one operation and waits for done; poke drives start/mthi/mtlo mid-operation.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi_e,
                        input logic [31:0] lo_e, input logic dz_e, input logic poke);
    int          cyc;
    logic        stable;
    logic [31:0] hi0, lo0;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0; rs_data = $urandom; rt_data = $urandom; op = 2'($urandom);
    chk({tag, "_busy_start"}, {31'b0, busy}, 32'd1);
    chk({tag, "_done_low"}, {31'b0, done}, 32'd0);
    hi0 = hi; lo0 = lo; stable = 1'b1; cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (poke && cyc == 5) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEADBEEF; op = 2'b00;
      end else if (poke && cyc == 6) begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      if (!done && (hi !== hi0 || lo !== lo0 || busy !== 1'b1)) stable = 1'b0;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd33);
    chk({tag, "_stable"}, {31'b0, stable}, 32'd1);
    chk({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
    chk({tag, "_dz"}, {31'b0, div_by_zero}, {31'b0, dz_e});
    chk({tag, "_hi"}, hi, hi_e);
    chk({tag, "_lo"}, lo, lo_e);
  endtask

  initial begin
    int seen_done;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dz", {31'b0, div_by_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
`ifdef MULDIV_SIGNED_EN
    run_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
    run_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0,
           1'b0);
`else
    run_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB, 1'b0, 1'b0);
    run_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 1'b0, 1'b0);
    run_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0,
           1'b0);
`endif
    // Back-to-back: the next call starts during the done cycle of the previous op.
    run_op("divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
    run_op("divu_zero", 2'b10, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("div_zero", 2'b11, 32'hFFFFFF00, 32'd0, 32'hFFFFFF00, 32'hFFFFFFFF, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("dz_pulse_width", {31'b0, div_by_zero}, 32'd0);
    chk("done_pulse_width", {31'b0, done}, 32'd0);

    @(negedge clk);
    mthi = 1'b1; wdata = 32'hAAAA5555;
    @(posedge clk); #1;
    mthi = 1'b0;
    chk("mthi_hi", hi, 32'hAAAA5555);
    chk("mthi_lo_kept", lo, 32'hFFFFFFFF);
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0BADF00D;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthilo_hi", hi, 32'h0BADF00D);
    chk("mthilo_lo", lo, 32'h0BADF00D);
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs_data = 32'd3; rt_data = 32'd5; mtlo = 1'b1; wdata = 32'h1;
    @(posedge clk); #1;
    start = 1'b0; mtlo = 1'b0;
    chk("start_wins_lo", lo, 32'h0BADF00D);
    repeat (40) @(posedge clk);
    #1;

    run_op("poke", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("no_queue_busy", {31'b0, busy}, 32'd0);

    @(negedge clk);
    start = 1'b1; op = 2'b11; rs_data = 32'd1000; rt_data = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen_done++;
    end
    chk("midrst_no_done", 32'(seen_done), 32'd0);
    run_op("after_rst", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
